// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle shift-add controller for the MUL instruction (alu_ctrl_i == 4'b0100).
// Latches operands when MUL issues from execute and runs Width shift-add steps. The pipeline
// is stalled until the product is ready, and then done_o pulses for one cycle. All other ALU
// codes are ignored, so those operations stay single-cycle.
//
// Ports:
//   clock_i     system clock; all state changes on the rising edge
//   reset_i     synchronous, active-high reset
//   start_i     execute stage holds a valid instruction this cycle
//   alu_ctrl_i  ALU control code (4'b0100 = MUL)
//   op_a_i      multiplicand (rs value)
//   op_b_i      multiplier (rt value)
//   flush_i     pipeline flush; aborts any sequence in progress
//   stall_o     hold IF/ID/EX registers (combinational in IDLE, state decode otherwise)
//   busy_o      sequencer is in RUN
//   done_o      one-cycle pulse; product_o is valid for this MUL
//   product_o   low Width bits of op_a_i * op_b_i; held until the next completed MUL
module mul_sequencer #(
  parameter int unsigned Width = 24
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [3:0]       alu_ctrl_i,
  input  logic [Width-1:0] op_a_i,
  input  logic [Width-1:0] op_b_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [Width-1:0] product_o
);

  localparam int unsigned    CntW    = (Width > 1) ? $clog2(Width) : 1;
  localparam logic [3:0]     AluMul  = 4'b0100;
  localparam logic [CntW-1:0] CntLast = CntW'(Width - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [Width-1:0]  acc_q, acc_d;
  logic [Width-1:0]  mcand_q, mcand_d;
  logic [Width-1:0]  mplier_q, mplier_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [Width-1:0]  product_q, product_d;
  logic              accept;

  assign accept = (state_q == StIdle) && start_i && (alu_ctrl_i == AluMul) && !flush_i;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    count_d   = count_q;
    product_d = product_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          acc_d = '0;
          if ((op_a_i == '0) || (op_b_i == '0)) begin
            // Zero operand: product is known, skip the shift-add loop.
            state_d = StDone;
          end else begin
            mcand_d  = op_a_i;
            mplier_d = op_b_i;
            count_d  = '0;
            state_d  = StRun;
          end
        end
      end
      StRun: begin
        if (flush_i) begin
          state_d = StIdle;
        end else begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + 1'b1;
          if (count_q == CntLast) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Product captures the final accumulator on entry to DONE, including the last step's add.
    if (state_d == StDone) begin
      product_d = acc_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  // Stall drops in DONE so the MUL advances in the same cycle its product is valid.
  assign stall_o   = accept || (state_q == StRun);
  assign busy_o    = (state_q == StRun);
  assign done_o    = (state_q == StDone) && !flush_i;
  assign product_o = product_q;

endmodule

// File: tb/tb_mul_sequencer.sv
module tb_mul_sequencer;

  localparam int unsigned Width = 24;
  localparam logic [3:0] AluMul = 4'b0100;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b1010;

  logic             clock;
  logic             reset;
  logic             start;
  logic [3:0]       alu_ctrl;
  logic [Width-1:0] op_a;
  logic [Width-1:0] op_b;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             done;
  logic [Width-1:0] product;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [Width-1:0] exp_q[$];

  mul_sequencer #(.Width(Width)) u_dut (
    .clock_i   (clock),
    .reset_i   (reset),
    .start_i   (start),
    .alu_ctrl_i(alu_ctrl),
    .op_a_i    (op_a),
    .op_b_i    (op_b),
    .flush_i   (flush),
    .stall_o   (stall),
    .busy_o    (busy),
    .done_o    (done),
    .product_o (product)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expected product.
  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_done", 32'(done), 32'd0);
      end else begin
        check_eq("product", 32'(product), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic check_ctl(input string tag, input logic es, input logic eb, input logic ed);
    check_eq({tag, "_stall"}, 32'(stall), 32'(es));
    check_eq({tag, "_busy"},  32'(busy),  32'(eb));
    check_eq({tag, "_done"},  32'(done),  32'(ed));
  endtask

  // Issue one MUL at cycle 0 and check stall/busy/done every cycle until done.
  task automatic run_mul(input string tag, input logic [Width-1:0] a, input logic [Width-1:0] b,
                         input logic [Width-1:0] expected);
    logic zero;
    int   last;
    zero = (a == '0) || (b == '0);
    last = zero ? 1 : Width + 1;
    exp_q.push_back(expected);
    start = 1'b1; alu_ctrl = AluMul; op_a = a; op_b = b;
    @(negedge clock);
    check_ctl({tag, "_c0"}, 1'b1, 1'b0, 1'b0);
    next_cycle();
    start = 1'b0;
    for (int c = 1; c <= last + 1; c++) begin
      @(negedge clock);
      if (c == 1 || c == Width || c >= last) begin
        check_ctl($sformatf("%s_c%0d", tag, c), (c < last), (!zero && c < last),
                  (c == last));
      end
      next_cycle();
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; alu_ctrl = '0; op_a = '0; op_b = '0; flush = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clock);
    check_ctl("reset", 1'b0, 1'b0, 1'b0);
    check_eq("reset_product", 32'(product), 32'd0);
    next_cycle();
    reset = 1'b0;
    next_cycle();

    run_mul("m3x5", 24'd3, 24'd5, 24'h00000F);
    run_mul("mffxff", 24'hFFFFFF, 24'hFFFFFF, 24'h000001);
    run_mul("trunc", 24'h001000, 24'h001000, 24'h000000);
    run_mul("msb", 24'h000800, 24'h001000, 24'h800000);

    // Non-MUL codes never stall and leave the product alone.
    start = 1'b1; alu_ctrl = AluAdd; op_a = 24'd1; op_b = 24'd2;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) alu_ctrl = AluSub;
      @(negedge clock);
      check_ctl($sformatf("nonmul_c%0d", c), 1'b0, 1'b0, 1'b0);
      check_eq("nonmul_product", 32'(product), 32'h800000);
      next_cycle();
    end
    start = 1'b0;

    // Flush mid-RUN: no done, product keeps 0x800000.
    start = 1'b1; alu_ctrl = AluMul; op_a = 24'd7; op_b = 24'd9;
    next_cycle();
    start = 1'b0;
    for (int c = 1; c < 10; c++) next_cycle();
    flush = 1'b1;
    @(negedge clock);
    check_ctl("flush_c10", 1'b1, 1'b1, 1'b0);
    next_cycle();
    flush = 1'b0;
    for (int c = 11; c < 40; c++) begin
      @(negedge clock);
      if (c == 11 || c == 25 || c == 26) check_ctl($sformatf("postflush_c%0d", c), 1'b0, 1'b0,
                                                   1'b0);
      next_cycle();
    end
    check_eq("flush_product", 32'(product), 32'h800000);
    run_mul("m2x4", 24'd2, 24'd4, 24'h000008);

    run_mul("zero", 24'd0, 24'h123456, 24'h000000);

    // Reset mid-RUN with flush and start also asserted.
    run_mul("pre_rst", 24'd5, 24'd6, 24'd30);
    start = 1'b1; alu_ctrl = AluMul; op_a = 24'd11; op_b = 24'd13;
    next_cycle();
    start = 1'b0;
    for (int c = 1; c < 12; c++) next_cycle();
    reset = 1'b1; flush = 1'b1; start = 1'b1;
    next_cycle();
    reset = 1'b0; flush = 1'b0; start = 1'b0;
    @(negedge clock);
    check_ctl("post_rst", 1'b0, 1'b0, 1'b0);
    check_eq("post_rst_product", 32'(product), 32'd0);
    next_cycle();

    // Start held through DONE: second accept only in IDLE, done pulses 26 cycles apart.
    exp_q.push_back(24'd21);
    exp_q.push_back(24'd21);
    start = 1'b1; alu_ctrl = AluMul; op_a = 24'd3; op_b = 24'd7;
    for (int c = 0; c <= 53; c++) begin
      if (c == 27) start = 1'b0;
      @(negedge clock);
      check_ctl($sformatf("b2b_c%0d", c),
                (c <= 24) || (c >= 26 && c <= 50),
                (c >= 1 && c <= 24) || (c >= 27 && c <= 50),
                (c == 25) || (c == 51));
      next_cycle();
    end

    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
